// File: rtl/battleship_game_ctrl.sv
// battleship_game_ctrl
//   Game-state controller for a 6x6 Battleship board. Conditions the player
//   inputs (2-flop synchroniser, previous-value flop, registered rising-edge
//   pulse), moves a wrapping cursor, records shots against a ship map latched
//   at game start and decides win/lose. Every output is a flop.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-low reset
//   start          level; rising edge starts/restarts a game
//   btn_up/down/left/right  debounced levels, cursor moves (wrap modulo 6)
//   btn_fire       debounced level, fire at the cursor cell
//   ship_array     ship map, bit r*6+c; latched when a game starts
//   cursor         one-hot cursor cell, zero outside PLAY
//   coloring_array bit set = cell fired at
//   hitmiss_array  bit set = fired cell held a ship
//   shots_left     remaining shots
//   hit_count      hits so far
//   game_over      high in WIN or LOSE
//   win            high in WIN
//   fsm_state      debug view of the controller state
//                  (0 IDLE, 1 PLAY, 2 CHECK, 3 WIN, 4 LOSE)
module battleship_game_ctrl #(
  parameter int MAX_SHOTS = 20,
  parameter int SHOT_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_fire,
  input  logic [35:0]       ship_array,
  output logic [35:0]       cursor,
  output logic [35:0]       coloring_array,
  output logic [35:0]       hitmiss_array,
  output logic [SHOT_W-1:0] shots_left,
  output logic [5:0]        hit_count,
  output logic              game_over,
  output logic              win,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_CHECK = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_t;

  localparam logic [SHOT_W-1:0] SHOTS_INIT = SHOT_W'(MAX_SHOTS);

  // Input bit order inside the conditioning vectors.
  localparam int B_RIGHT = 0;
  localparam int B_LEFT  = 1;
  localparam int B_DOWN  = 2;
  localparam int B_UP    = 3;
  localparam int B_FIRE  = 4;
  localparam int B_START = 5;

  logic [5:0] raw_in;
  logic [5:0] sync1, sync2, prev, pulse;

  state_t      state, state_n;
  logic [2:0]  row, col, row_n, col_n;
  logic [35:0] ship_reg, ship_n;
  logic [35:0] color_n, hm_n;
  logic [SHOT_W-1:0] shots_n;
  logic [5:0]  hits_n;
  logic [5:0]  idx, idx_n;

  assign raw_in    = {start, btn_fire, btn_up, btn_down, btn_left, btn_right};
  assign fsm_state = state;

  // The edge pulse is itself registered, so a level first sampled at edge k
  // pulses in the cycle after edge k+2 and acts at edge k+3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      pulse <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      prev  <= sync2;
      pulse <= sync2 & ~prev;
    end
  end

  assign idx   = 6'(row) * 6'd6 + 6'(col);
  assign idx_n = 6'(row_n) * 6'd6 + 6'(col_n);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      row            <= '0;
      col            <= '0;
      ship_reg       <= '0;
      coloring_array <= '0;
      hitmiss_array  <= '0;
      shots_left     <= SHOTS_INIT;
      hit_count      <= '0;
      cursor         <= '0;
      game_over      <= 1'b0;
      win            <= 1'b0;
    end else begin
      state          <= state_n;
      row            <= row_n;
      col            <= col_n;
      ship_reg       <= ship_n;
      coloring_array <= color_n;
      hitmiss_array  <= hm_n;
      shots_left     <= shots_n;
      hit_count      <= hits_n;
      // Display outputs are registered from the next-state values so they
      // line up with the state they describe.
      cursor         <= (state_n == S_PLAY) ? (36'd1 << idx_n) : '0;
      game_over      <= (state_n == S_WIN) || (state_n == S_LOSE);
      win            <= (state_n == S_WIN);
    end
  end

  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    ship_n  = ship_reg;
    color_n = coloring_array;
    hm_n    = hitmiss_array;
    shots_n = shots_left;
    hits_n  = hit_count;

    case (state)
      S_IDLE, S_WIN, S_LOSE: begin
        // An empty map re-initialises into IDLE, which leaves every register
        // at its reset value.
        if (pulse[B_START]) begin
          ship_n  = ship_array;
          color_n = '0;
          hm_n    = '0;
          shots_n = SHOTS_INIT;
          hits_n  = '0;
          row_n   = '0;
          col_n   = '0;
          state_n = (ship_array != '0) ? S_PLAY : S_IDLE;
        end
      end

      S_PLAY: begin
        // A fire pulse swallows any move in the same cycle, even when the
        // cell was already fired at.
        if (pulse[B_FIRE]) begin
          if (!coloring_array[idx]) begin
            color_n[idx] = 1'b1;
            hm_n[idx]    = ship_reg[idx];
            shots_n      = shots_left - SHOT_W'(1);
            if (ship_reg[idx]) hits_n = hit_count + 6'd1;
            state_n      = S_CHECK;
          end
        end else if (pulse[B_UP]) begin
          row_n = (row == 3'd0) ? 3'd5 : row - 3'd1;
        end else if (pulse[B_DOWN]) begin
          row_n = (row == 3'd5) ? 3'd0 : row + 3'd1;
        end else if (pulse[B_LEFT]) begin
          col_n = (col == 3'd0) ? 3'd5 : col - 3'd1;
        end else if (pulse[B_RIGHT]) begin
          col_n = (col == 3'd5) ? 3'd0 : col + 3'd1;
        end
      end

      S_CHECK: begin
        // Sinking the last ship cell with the last shot is a win.
        if ((hitmiss_array & ship_reg) == ship_reg) state_n = S_WIN;
        else if (shots_left == '0)                  state_n = S_LOSE;
        else                                        state_n = S_PLAY;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_battleship_game_ctrl.sv
module tb_battleship_game_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic btn_right = 1'b0, btn_fire = 1'b0;
  logic [35:0] ship_array = '0;

  logic [35:0] cursor1, color1, hm1, cursor2, color2, hm2;
  logic [5:0]  shots1, hits1, shots2, hits2;
  logic        over1, win1, over2, win2;
  logic [2:0]  st1, st2;

  battleship_game_ctrl #(.MAX_SHOTS(20), .SHOT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .btn_up(btn_up),
    .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_fire(btn_fire), .ship_array(ship_array), .cursor(cursor1),
    .coloring_array(color1), .hitmiss_array(hm1), .shots_left(shots1),
    .hit_count(hits1), .game_over(over1), .win(win1), .fsm_state(st1)
  );

  battleship_game_ctrl #(.MAX_SHOTS(3), .SHOT_W(6)) dut3 (
    .clk(clk), .reset(reset), .start(start), .btn_up(btn_up),
    .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_fire(btn_fire), .ship_array(ship_array), .cursor(cursor2),
    .coloring_array(color2), .hitmiss_array(hm2), .shots_left(shots2),
    .hit_count(hits2), .game_over(over2), .win(win2), .fsm_state(st2)
  );

  // Button mask bits: start, fire, up, down, left, right.
  localparam logic [5:0] M_START = 6'b100000;
  localparam logic [5:0] M_FIRE  = 6'b010000;
  localparam logic [5:0] M_UP    = 6'b001000;
  localparam logic [5:0] M_DOWN  = 6'b000100;
  localparam logic [5:0] M_LEFT  = 6'b000010;
  localparam logic [5:0] M_RIGHT = 6'b000001;

  localparam logic [35:0] SHIP35 = 36'h8_0000_0000;

  int checks = 0;
  int errors = 0;

  function automatic logic [121:0] mk(logic [35:0] c, logic [35:0] co,
                                      logic [35:0] h, logic [5:0] s,
                                      logic [5:0] n, logic o, logic w);
    return {c, co, h, s, n, o, w};
  endfunction

  function automatic logic [121:0] snap1();
    return {cursor1, color1, hm1, shots1, hits1, over1, win1};
  endfunction

  function automatic logic [121:0] snap2();
    return {cursor2, color2, hm2, shots2, hits2, over2, win2};
  endfunction

  task automatic chk(input string name, input logic [121:0] act,
                     input logic [121:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic set_btns(input logic [5:0] m);
    {start, btn_fire, btn_up, btn_down, btn_left, btn_right} = m;
  endtask

  // Hold the mask for len cycles, release, then let the pipeline and any
  // CHECK cycle settle before the caller samples.
  task automatic drive(input logic [5:0] m, input int len, input logic [35:0] ship);
    @(negedge clk);
    ship_array = ship;
    set_btns(m);
    repeat (len) @(negedge clk);
    set_btns(6'b0);
    repeat (7) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    set_btns(6'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [5:0]   mask;
    int           len;
    logic [35:0]  ship;
    logic [121:0] exp;
    string        name;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [5:0] m, input int len, input logic [35:0] ship,
                     input logic [121:0] exp, input string name);
    vec_t v;
    v.mask = m; v.len = len; v.ship = ship; v.exp = exp; v.name = name;
    vq.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 play, 2 won, 3 lost
  int          m_mode, m_row, m_col, m_shots, m_hits;
  bit          m_fired[36];
  logic [35:0] m_ship;
  logic [121:0] exp_q[$];

  function automatic logic [121:0] model_expect();
    logic [35:0] c, co;
    co = '0;
    for (int i = 0; i < 36; i++) co[i] = m_fired[i];
    c = (m_mode == 1) ? (36'd1 << (m_row * 6 + m_col)) : 36'd0;
    return mk(c, co, co & m_ship, 6'(m_shots), 6'(m_hits),
              m_mode >= 2, m_mode == 2);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_row = 0; m_col = 0; m_shots = 20; m_hits = 0; m_ship = '0;
    for (int i = 0; i < 36; i++) m_fired[i] = 1'b0;
  endtask

  task automatic model_apply(input logic [5:0] m, input logic [35:0] ship);
    int  i;
    bit  all_sunk;
    if (m_mode != 1) begin
      if (m[5]) begin
        model_reset();
        m_ship = ship;
        m_mode = (ship != 0) ? 1 : 0;
      end
    end else if (m[4]) begin
      i = m_row * 6 + m_col;
      if (!m_fired[i]) begin
        m_fired[i] = 1'b1;
        m_shots--;
        if (m_ship[i]) m_hits++;
        all_sunk = 1'b1;
        for (int k = 0; k < 36; k++)
          if (m_ship[k] && !m_fired[k]) all_sunk = 1'b0;
        if (all_sunk)          m_mode = 2;
        else if (m_shots == 0) m_mode = 3;
      end
    end else if (m[3]) m_row = (m_row + 5) % 6;
    else if (m[2])     m_row = (m_row + 1) % 6;
    else if (m[1])     m_col = (m_col + 5) % 6;
    else if (m[0])     m_col = (m_col + 1) % 6;
  endtask

  function automatic logic [35:0] rand_ship();
    logic [35:0] s;
    int n;
    s = '0;
    n = $urandom_range(0, 5);
    if (n == 0) return s;
    for (int k = 0; k < (n > 3 ? 3 : n); k++) s[$urandom_range(0, 35)] = 1'b1;
    return s;
  endfunction

  // ---------------- stimulus ----------------
  logic [121:0] rst_exp;

  initial begin
    rst_exp = mk(36'h0, 36'h0, 36'h0, 6'd20, 6'd0, 1'b0, 1'b0);

    // Game 1: ship in cells 0..2, cursor moves, wrap, hits, win.
    add(M_START, 1, 36'h7, mk(36'h1, 0, 0, 20, 0, 0, 0), "start_play");
    add(M_LEFT,  1, 36'h7, mk(36'h20, 0, 0, 20, 0, 0, 0), "left_wrap");
    add(M_UP,    1, 36'h7, mk(SHIP35, 0, 0, 20, 0, 0, 0), "up_wrap");
    add(M_DOWN,  1, 36'h7, mk(36'h20, 0, 0, 20, 0, 0, 0), "down_wrap");
    add(M_RIGHT, 1, 36'h7, mk(36'h1, 0, 0, 20, 0, 0, 0), "right_wrap");
    add(M_RIGHT, 50, 36'h7, mk(36'h2, 0, 0, 20, 0, 0, 0), "right_held");
    add(M_LEFT,  1, 36'h7, mk(36'h1, 0, 0, 20, 0, 0, 0), "left_back");
    add(M_FIRE,  1, 36'h7, mk(36'h1, 36'h1, 36'h1, 19, 1, 0, 0), "fire_hit");
    add(M_FIRE,  1, 36'h7, mk(36'h1, 36'h1, 36'h1, 19, 1, 0, 0), "fire_again");
    add(M_RIGHT, 1, 36'h7, mk(36'h2, 36'h1, 36'h1, 19, 1, 0, 0), "right_1");
    add(M_FIRE,  1, 36'h7, mk(36'h2, 36'h3, 36'h3, 18, 2, 0, 0), "fire_hit2");
    add(M_RIGHT, 1, 36'h7, mk(36'h4, 36'h3, 36'h3, 18, 2, 0, 0), "right_2");
    add(M_FIRE,  1, 36'h7, mk(36'h0, 36'h7, 36'h7, 17, 3, 1, 1), "fire_win");
    add(M_UP,    1, 36'h7, mk(36'h0, 36'h7, 36'h7, 17, 3, 1, 1), "win_frozen");
    // Game 2: restart from WIN, start in PLAY is ignored, priorities.
    add(M_START, 1, SHIP35, mk(36'h1, 0, 0, 20, 0, 0, 0), "restart");
    add(M_START, 1, 36'h1, mk(36'h1, 0, 0, 20, 0, 0, 0), "start_in_play");
    add(M_FIRE,  1, 36'h1, mk(36'h1, 36'h1, 36'h0, 19, 0, 0, 0), "fire_miss");
    add(M_DOWN,  1, 36'h1, mk(36'h40, 36'h1, 0, 19, 0, 0, 0), "down_1");
    add(M_DOWN,  1, 36'h1, mk(36'h1000, 36'h1, 0, 19, 0, 0, 0), "down_2");
    add(M_RIGHT, 1, 36'h1, mk(36'h2000, 36'h1, 0, 19, 0, 0, 0), "right_3");
    add(M_RIGHT, 1, 36'h1, mk(36'h4000, 36'h1, 0, 19, 0, 0, 0), "right_4");
    add(M_FIRE | M_RIGHT, 1, 36'h1, mk(36'h4000, 36'h4001, 0, 18, 0, 0, 0), "fire_beats_move");
    add(M_UP | M_DOWN | M_LEFT | M_RIGHT, 1, 36'h1,
        mk(36'h100, 36'h4001, 0, 18, 0, 0, 0), "prio_up");
    add(M_DOWN | M_LEFT | M_RIGHT, 1, 36'h1,
        mk(36'h4000, 36'h4001, 0, 18, 0, 0, 0), "prio_down");
    add(M_LEFT | M_RIGHT, 1, 36'h1, mk(36'h2000, 36'h4001, 0, 18, 0, 0, 0), "prio_left");

    repeat (2) @(negedge clk);
    chk("reset_state", snap1(), rst_exp);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_release", snap1(), rst_exp);

    foreach (vq[i]) begin
      drive(vq[i].mask, vq[i].len, vq[i].ship);
      chk(vq[i].name, snap1(), vq[i].exp);
    end

    // Fire latency at (2,1) and the single CHECK cycle, then reset in CHECK.
    @(negedge clk);
    btn_fire = 1'b1;                       // first sampled at edge k
    repeat (3) @(negedge clk);             // after edge k+2
    chk("fire_lat_k2", snap1(), mk(36'h2000, 36'h4001, 0, 18, 0, 0, 0));
    @(negedge clk);                        // after edge k+3: CHECK
    chk("fire_lat_k3", snap1(), mk(36'h0, 36'h6001, 0, 17, 0, 0, 0));
    chk("check_state", 122'(st1), 122'(2));
    reset = 1'b0;
    #1;
    chk("reset_in_check", snap1(), rst_exp);
    chk("reset_state_idle", 122'(st1), 122'(0));
    btn_fire = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    drive(M_START, 1, 36'h0);
    chk("start_empty_map", snap1(), rst_exp);
    chk("start_empty_idle", 122'(st1), 122'(0));

    // Move latency.
    drive(M_START, 1, 36'h7);
    chk("start_again", snap1(), mk(36'h1, 0, 0, 20, 0, 0, 0));
    @(negedge clk);
    btn_right = 1'b1;
    repeat (3) @(negedge clk);
    chk("move_lat_k2", snap1(), mk(36'h1, 0, 0, 20, 0, 0, 0));
    @(negedge clk);
    chk("move_lat_k3", snap1(), mk(36'h2, 0, 0, 20, 0, 0, 0));
    btn_right = 1'b0;
    repeat (4) @(negedge clk);

    // Three-shot game on the MAX_SHOTS=3 instance: lose.
    do_reset();
    chk("max3_reset", snap2(), mk(0, 0, 0, 3, 0, 0, 0));
    drive(M_START, 1, SHIP35);
    drive(M_FIRE, 1, SHIP35);
    drive(M_RIGHT, 1, SHIP35);
    drive(M_FIRE, 1, SHIP35);
    chk("max3_two_shots", snap2(), mk(36'h2, 36'h3, 0, 1, 0, 0, 0));
    drive(M_RIGHT, 1, SHIP35);
    drive(M_FIRE, 1, SHIP35);
    chk("max3_lose", snap2(), mk(0, 36'h7, 0, 0, 0, 1, 0));
    drive(M_FIRE, 1, SHIP35);
    chk("max3_lose_frozen", snap2(), mk(0, 36'h7, 0, 0, 0, 1, 0));

    // Randomised games against the reference model.
    do_reset();
    model_reset();
    chk("rand_reset", snap1(), model_expect());
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  m;
      logic [35:0] s;
      int r;
      r = $urandom_range(0, 99);
      s = ship_array;
      if (m_mode != 1 && r < 30) begin
        m = M_START;
        s = rand_ship();
      end else if (r < 40) begin
        m = M_FIRE;
      end else if (r < 85) begin
        m = 6'b000001 << $urandom_range(0, 3);
      end else if (r < 97) begin
        m = 6'($urandom_range(0, 31));
        // Only the unambiguous fire+move combinations are generated.
        if (m[4] && m_mode == 1 && m_fired[m_row * 6 + m_col]) m = M_FIRE;
      end else begin
        m = M_START;
        s = rand_ship();
      end
      model_apply(m, s);
      exp_q.push_back(model_expect());
      drive(m, $urandom_range(1, 3), s);
      chk("rand", snap1(), exp_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/battleship_game_ctrl.md
Name: battleship_game_ctrl

Overview:
Game-state controller for the 6x6 Battleship board that directly feeds the VGA display stage. It synchronises and edge-detects the player buttons and moves a one-hot cursor with wrap-around. It records shots against a latched ship map and produces the three 36-bit arrays the display consumes: cursor, coloring_array and hitmiss_array. It also tracks shots remaining and hits, and declares win or lose.

Parameters:
MAX_SHOTS, 20, shots allowed per game (1..63)
SHOT_W, 6, width of shots_left counter

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-low reset
start  in  1  level; rising edge starts or restarts a game
btn_up  in  1  debounced level, cursor row-1
btn_down  in  1  debounced level, cursor row+1
btn_left  in  1  debounced level, cursor col-1
btn_right  in  1  debounced level, cursor col+1
btn_fire  in  1  debounced level, fire at cursor cell
ship_array  in  36  ship map, bit r*6+c = ship present; latched on start
cursor  out  36  one-hot cursor cell, 0 when not in PLAY
coloring_array  out  36  bit set = cell has been fired at
hitmiss_array  out  36  bit set = fired cell contained a ship (valid only where coloring_array=1)
shots_left  out  SHOT_W  remaining shots
hit_count  out  6  number of hits so far
game_over  out  1  high in WIN or LOSE
win  out  1  high in WIN only

Behaviour:
- Reset (reset=0, async) values:
  - State=IDLE; row=col=0; ship_reg=0.
  - cursor=0, coloring_array=0, hitmiss_array=0.
  - shots_left=MAX_SHOTS, hit_count=0, game_over=0, win=0.
  - Sync/edge flops are cleared.
- Input conditioning: all six inputs pass through a 2-flop synchroniser followed by a previous-value flop.
  - edge = sync2 & ~prev.
  - An input first sampled high at clock edge k produces its edge pulse in the cycle after edge k+2.
  - The resulting register update is visible after edge k+3.
  - A held input yields exactly one edge.
- States: IDLE, PLAY, CHECK, WIN, LOSE.
- IDLE:
  - All outputs hold their reset values.
  - On a start edge with ship_array!=0: latch ship_reg=ship_array, clear both arrays, set hit_count=0, shots_left=MAX_SHOTS, row=col=0, and go to PLAY.
  - On a start edge with ship_array==0: remain in IDLE.
- PLAY:
  - cursor = 1<<(row*6+col).
  - Move edges update row/col modulo 6: up from row 0 gives row 5, down from row 5 gives row 0, left and right wrap the same way on col.
  - Multiple move edges in one cycle: only the highest priority applies, in the order up > down > left > right.
  - Fire edge, idx=row*6+col:
    - If coloring_array[idx]=0: set coloring_array[idx]=1, set hitmiss_array[idx]=ship_reg[idx], decrement shots_left, increment hit_count if ship_reg[idx]=1, then go to CHECK.
    - If coloring_array[idx]=1: ignore, consume no shot, stay in PLAY.
  - Fire and move in the same cycle: fire wins and the move is discarded.
  - A start edge in PLAY is ignored.
- CHECK (exactly one cycle):
  - All button edges are discarded.
  - If (hitmiss_array & ship_reg)==ship_reg: go to WIN.
  - Else if shots_left==0: go to LOSE.
  - Else: go to PLAY.
  - Win takes priority when the last shot sinks the last ship cell.
- WIN: game_over=1, win=1, cursor=0, arrays frozen.
- LOSE: game_over=1, win=0, cursor=0, arrays frozen.
- From WIN or LOSE: a start edge performs the same initialisation as IDLE and goes to PLAY, or to IDLE if ship_array==0.
- Reset mid-game returns all registers to reset values immediately (async), regardless of state.
- All outputs are registered, with no combinational path from input to output.
- Width rules:
  - shots_left never decrements below 0. CHECK prevents any fire once it reaches 0.
  - hit_count saturates at 36 by construction, since each cell can be fired at most once.

Test Plan:
1. Reset then start edge with ship_array=36'h0_0000_0007 -> PLAY, cursor=36'h1, shots_left=20, coloring_array=0.
2. From (0,0): pulse left once, then up once -> cursor at (0,5) then (5,5), cursor=1<<35. Holding btn_right for 50 cycles moves exactly one column.
3. Fire at (0,0) -> coloring_array bit0=1, hitmiss_array bit0=1, hit_count=1, shots_left=19. Fire again at (0,0) -> no change and shots_left stays 19.
4. Fire at cells 0, 1 and 2 (after moving right between shots) -> after the third shot's CHECK cycle, win=1, game_over=1, cursor=0.
5. MAX_SHOTS=3 with ship at cell 35 only: fire at cells 0, 1, 2 -> LOSE, win=0, game_over=1, coloring_array=36'h7, hitmiss_array=0.
6. Assert fire and right in the same cycle at (2,2) -> cell 14 fired and col stays 2. Assert reset during CHECK -> all outputs return to reset values; a later start edge with ship_array=0 stays in IDLE.
